// File: rtl/alu_flag_register_pkg.sv
// Shared relay-ALU types: sequencing state and the condition-flag bundle
// that this unit produces and the sequencer branches on.
package alu_flag_register_pkg;

  // IDLE waits for a result; SETTLE models relay ripple time before flags commit.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } alu_state_e;

  // Condition flags as seen by the sequencer's branch logic.
  typedef struct packed {
    logic zero;
    logic sign;
    logic carry;
  } alu_flags_t;

  // Bits needed to hold a settle count of settle-1 (always at least one bit).
  function automatic int settle_cnt_width(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/alu_flag_register_if.sv
// Result-bus / condition-flag bundle between the ALU, this flag unit and the
// sequencer. The master side is the ALU/sequencer; the slave side is the
// flag unit.
interface alu_flag_register_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] result;
  logic             carry_in;
  logic             clear;
  logic             busy;
  logic             flags_valid;
  logic             zero;
  logic             sign;
  logic             carry;
  logic             overrun;

  modport master (
    output load, result, carry_in, clear,
    input  busy, flags_valid, zero, sign, carry, overrun
  );

  modport slave (
    input  load, result, carry_in, clear,
    output busy, flags_valid, zero, sign, carry, overrun
  );

endinterface

// File: rtl/alu_flag_register_zero_chain.sv
// Ripple zero detector: ANDs the inverted result bits one after another,
// bit 0 first, the same way the relay chain passes "still zero" down the line.
module zero_chain #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic             all_zero
);

  logic [WIDTH:0] chain;

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_link
    assign chain[i+1] = chain[i] & ~value[i];
  end

  assign all_zero = chain[WIDTH];

endmodule

// File: rtl/alu_flag_register.sv
// Condition-flag unit for the relay ALU. A load captures the result and
// carry, waits SETTLE cycles to model relay ripple, then commits zero/sign/
// carry and pulses flags_valid. Flags hold between updates; a load that
// arrives while settling is dropped and latched as a sticky overrun.
module alu_flag_register
  import alu_flag_register_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_flag_register_if.slave   bus
);

  localparam int             CNT_W    = settle_cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_result_q, hold_result_d;
  logic             hold_carry_q, hold_carry_d;
  alu_flags_t       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             held_zero;

  // Zero is always taken from the captured value, never from the live bus.
  zero_chain #(
    .WIDTH (WIDTH)
  ) u_zero_chain (
    .value    (hold_result_q),
    .all_zero (held_zero)
  );

  // Next-state logic: accept/clear in IDLE, count down and commit in SETTLE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_result_d = hold_result_q;
    hold_carry_d  = hold_carry_q;
    flags_d       = flags_q;
    valid_d       = 1'b0;
    overrun_d     = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          flags_d = '0;
        end
        if (bus.load) begin
          hold_result_d = bus.result;
          hold_carry_d  = bus.carry_in;
          cnt_d         = CNT_LOAD;
          state_d       = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (bus.load) begin
          overrun_d = 1'b1;
        end
        if (cnt_q == '0) begin
          flags_d.zero  = held_zero;
          flags_d.sign  = hold_result_q[WIDTH-1];
          flags_d.carry = hold_carry_q;
          valid_d       = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, capture and flag registers; reset discards any capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hold_result_q <= '0;
      hold_carry_q  <= 1'b0;
      flags_q       <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_result_q <= hold_result_d;
      hold_carry_q  <= hold_carry_d;
      flags_q       <= flags_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.busy        = (state_q == ST_SETTLE);
  assign bus.flags_valid = valid_q;
  assign bus.zero        = flags_q.zero;
  assign bus.sign        = flags_q.sign;
  assign bus.carry       = flags_q.carry;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_alu_flag_register.sv
// Bench for alu_flag_register: one instance at WIDTH=8/SETTLE=8 and one at
// WIDTH=16/SETTLE=1, each compared every cycle against a timeline model that
// remembers when an evaluation was accepted and when it is due.
module tb_alu_flag_register;

  logic clk = 1'b0;
  logic rstA_n;
  logic rstB_n;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  alu_flag_register_if #(.WIDTH(8))  busA ();
  alu_flag_register_if #(.WIDTH(16)) busB ();

  alu_flag_register #(.WIDTH(8), .SETTLE(8)) dutA (
    .clk   (clk),
    .rst_n (rstA_n),
    .bus   (busA.slave)
  );

  alu_flag_register #(.WIDTH(16), .SETTLE(1)) dutB (
    .clk   (clk),
    .rst_n (rstB_n),
    .bus   (busB.slave)
  );

  int total = 0;
  int bad   = 0;
  int edgeNum = 0;

  int settleOf [2] = '{8, 1};
  int widthOf  [2] = '{8, 16};

  // Reference model state: an evaluation is "in flight" from its accept edge
  // until the edge SETTLE cycles later, when its captured flags become visible.
  bit          inFlight  [2];
  int          accEdge   [2];
  logic [15:0] heldRes   [2];
  bit          heldCarry [2];
  bit          mZero     [2];
  bit          mSign     [2];
  bit          mCarry    [2];
  bit          mOverrun  [2];
  bit          mValid    [2];

  bit          curLoad   [2];
  bit          curClear  [2];
  bit          curCarry  [2];
  logic [15:0] curRes    [2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit ld, input logic [15:0] res, input bit cin, input bit clr);
    curLoad[idx]  = ld;
    curClear[idx] = clr;
    curCarry[idx] = cin;
    curRes[idx]   = (idx == 0) ? {8'h00, res[7:0]} : res;
    if (idx == 0) begin
      busA.load     = ld;
      busA.result   = res[7:0];
      busA.carry_in = cin;
      busA.clear    = clr;
    end else begin
      busB.load     = ld;
      busB.result   = res;
      busB.carry_in = cin;
      busB.clear    = clr;
    end
  endtask

  function automatic logic [5:0] readOut(input int idx);
    if (idx == 0)
      return {busA.busy, busA.flags_valid, busA.zero, busA.sign, busA.carry, busA.overrun};
    else
      return {busB.busy, busB.flags_valid, busB.zero, busB.sign, busB.carry, busB.overrun};
  endfunction

  task automatic modelReset(input int idx);
    inFlight[idx] = 0;
    mZero[idx]    = 0;
    mSign[idx]    = 0;
    mCarry[idx]   = 0;
    mOverrun[idx] = 0;
    mValid[idx]   = 0;
  endtask

  // What one rising edge does to the model, given the inputs presented to it.
  task automatic modelEdge(input int idx);
    mValid[idx] = 0;
    if (inFlight[idx]) begin
      if (curLoad[idx]) mOverrun[idx] = 1;
      if (edgeNum == accEdge[idx] + settleOf[idx]) begin
        mZero[idx]    = (heldRes[idx] == 16'h0000);
        mSign[idx]    = heldRes[idx][widthOf[idx]-1];
        mCarry[idx]   = heldCarry[idx];
        mValid[idx]   = 1;
        inFlight[idx] = 0;
      end
    end else begin
      if (curClear[idx]) begin
        mZero[idx]  = 0;
        mSign[idx]  = 0;
        mCarry[idx] = 0;
      end
      if (curLoad[idx]) begin
        heldRes[idx]   = curRes[idx];
        heldCarry[idx] = curCarry[idx];
        accEdge[idx]   = edgeNum;
        inFlight[idx]  = 1;
      end
    end
  endtask

  task automatic checkAll(input int idx, input string pfx);
    logic [5:0] o;
    o = readOut(idx);
    checkOutput($sformatf("%s.busy", pfx),    32'(o[5]), 32'(inFlight[idx]));
    checkOutput($sformatf("%s.valid", pfx),   32'(o[4]), 32'(mValid[idx]));
    checkOutput($sformatf("%s.zero", pfx),    32'(o[3]), 32'(mZero[idx]));
    checkOutput($sformatf("%s.sign", pfx),    32'(o[2]), 32'(mSign[idx]));
    checkOutput($sformatf("%s.carry", pfx),   32'(o[1]), 32'(mCarry[idx]));
    checkOutput($sformatf("%s.overrun", pfx), 32'(o[0]), 32'(mOverrun[idx]));
  endtask

  task automatic step(input int idx, input string pfx);
    @(posedge clk);
    edgeNum++;
    modelEdge(idx);
    #1;
    checkAll(idx, pfx);
  endtask

  task automatic runIdle(input int idx, input int n, input string pfx);
    applyStimulus(idx, 0, curRes[idx], 0, 0);
    for (int i = 0; i < n; i++) step(idx, pfx);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must drop at once.
  task automatic resetDut(input int idx, input string pfx);
    if (idx == 0) rstA_n = 1'b0; else rstB_n = 1'b0;
    #1;
    modelReset(idx);
    checkAll(idx, pfx);
    @(negedge clk);
    if (idx == 0) rstA_n = 1'b1; else rstB_n = 1'b1;
  endtask

  task automatic randomRun(input int idx, input int cycles, input string pfx);
    bit          ld, clr, cin;
    logic [15:0] res;
    int          kind;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 149) == 0) resetDut(idx, {pfx, ".rst"});
      ld   = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 4) == 0);
      cin  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      res  = 16'($urandom);
      if (kind == 0) res = 16'h0000;
      if (kind == 1) res[widthOf[idx]-1] = 1'b1;
      applyStimulus(idx, ld, res, cin, clr);
      step(idx, pfx);
    end
    runIdle(idx, settleOf[idx] + 1, pfx);
  endtask

  initial begin
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    modelReset(0);
    modelReset(1);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkAll(0, "rstA");
    checkAll(1, "rstB");
    @(negedge clk);
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    runIdle(0, 2, "idleA");

    // Zero result: busy for the settle window, then zero=1 with one pulse.
    applyStimulus(0, 1, 16'h0000, 0, 0);
    step(0, "zeroA");
    runIdle(0, 8, "zeroA");
    checkOutput("zeroA.pulse", 32'(busA.flags_valid), 32'd1);
    checkOutput("zeroA.flag", 32'(busA.zero), 32'd1);
    runIdle(0, 1, "zeroA");

    // Sign+carry; the live bus changes mid-settle and must not leak through.
    applyStimulus(0, 1, 16'h0080, 1, 0);
    step(0, "signA");
    applyStimulus(0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 8; i++) step(0, "signA");
    checkOutput("signA.zero", 32'(busA.zero), 32'd0);
    checkOutput("signA.sign", 32'(busA.sign), 32'd1);
    checkOutput("signA.carry", 32'(busA.carry), 32'd1);

    // Load while settling is dropped and latched as overrun.
    applyStimulus(0, 1, 16'h0005, 0, 0);
    step(0, "ovrA");
    runIdle(0, 2, "ovrA");
    applyStimulus(0, 1, 16'h0000, 1, 0);
    step(0, "ovrA");
    runIdle(0, 5, "ovrA");
    checkOutput("ovrA.pulse", 32'(busA.flags_valid), 32'd1);
    checkOutput("ovrA.zero", 32'(busA.zero), 32'd0);
    checkOutput("ovrA.sticky", 32'(busA.overrun), 32'd1);

    // Clear alone, then clear together with a load of zero.
    applyStimulus(0, 1, 16'h0000, 0, 0);
    step(0, "clrA");
    runIdle(0, 8, "clrA");
    applyStimulus(0, 0, 16'h0000, 0, 1);
    step(0, "clrA");
    checkOutput("clrA.zero", 32'(busA.zero), 32'd0);
    applyStimulus(0, 1, 16'h0000, 0, 0);
    step(0, "clrA");
    runIdle(0, 8, "clrA");
    applyStimulus(0, 1, 16'h0000, 0, 1);
    step(0, "clrLdA");
    checkOutput("clrLdA.zeroNow", 32'(busA.zero), 32'd0);
    runIdle(0, 8, "clrLdA");
    checkOutput("clrLdA.zeroLater", 32'(busA.zero), 32'd1);
    checkOutput("clrLdA.overrun", 32'(busA.overrun), 32'd1);

    // Reset in the middle of a settle window, then a clean evaluation.
    applyStimulus(0, 1, 16'h00ff, 1, 0);
    step(0, "midRstA");
    runIdle(0, 4, "midRstA");
    resetDut(0, "midRstA.rst");
    checkOutput("midRstA.busy", 32'(busA.busy), 32'd0);
    applyStimulus(0, 1, 16'h0001, 0, 0);
    step(0, "midRstA");
    runIdle(0, 8, "midRstA");
    checkOutput("midRstA.zero", 32'(busA.zero), 32'd0);
    checkOutput("midRstA.pulse", 32'(busA.flags_valid), 32'd1);

    randomRun(0, 400, "rndA");

    // WIDTH=16, SETTLE=1: one-cycle settle and back-to-back acceptance.
    applyStimulus(1, 1, 16'h0000, 0, 0);
    step(1, "fastB");
    checkOutput("fastB.busy", 32'(busB.busy), 32'd1);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    step(1, "fastB");
    checkOutput("fastB.zero", 32'(busB.zero), 32'd1);
    checkOutput("fastB.pulse", 32'(busB.flags_valid), 32'd1);
    applyStimulus(1, 1, 16'h0100, 0, 0);
    step(1, "fastB");
    checkOutput("fastB.accept", 32'(busB.busy), 32'd1);
    applyStimulus(1, 0, 16'h0000, 0, 0);
    step(1, "fastB");
    checkOutput("fastB.zero2", 32'(busB.zero), 32'd0);
    checkOutput("fastB.overrun", 32'(busB.overrun), 32'd0);

    randomRun(1, 300, "rndB");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_flag_register.md
# alu_flag_register

Parametrised condition-flag unit for the relay ALU. It generalises the 8-bit ripple zero detector to any result width, adds sign and carry flags, and models the relay chain's settling time as a programmable busy window. Flags are registered and held until the next completed update, so the sequencer can branch on stable values. It sits between the ALU result bus and the sequencer's branch/condition logic.

## Interface
Parameters:
- WIDTH, 8, result bus width in bits; must be at least 1.
- SETTLE, 8, cycles from load acceptance to flag update, modelling relay ripple time; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load  in  1  request to evaluate `result`/`carry_in`; accepted only in IDLE.
- result  in  WIDTH  ALU result; sampled on the accepting edge.
- carry_in  in  1  ALU carry-out; sampled with `result`.
- clear  in  1  synchronous clear of zero/sign/carry; honoured only in IDLE.
- busy  out  1  high while in SETTLE.
- flags_valid  out  1  one-cycle pulse on the cycle flags change from an update.
- zero  out  1  registered: captured result equals 0.
- sign  out  1  registered: captured result[WIDTH-1].
- carry  out  1  registered: captured carry_in.
- overrun  out  1  sticky: a `load` arrived while busy.

## Operation
- States: IDLE and SETTLE.
- IDLE with load=1:
  - capture result and carry_in into holding registers;
  - load the counter with SETTLE-1;
  - go to SETTLE.
- SETTLE with counter > 0: decrement the counter.
- SETTLE with counter = 0:
  - write zero/sign/carry from the holding registers;
  - assert flags_valid for one cycle;
  - return to IDLE.
- Zero is computed on the held value through the ripple chain sub-module (active-high when all WIDTH bits are 0). Flags never reflect live `result`.
- load while in SETTLE:
  - ignored, and the capture is not disturbed;
  - set overrun, which holds until reset.
- clear in IDLE without load: zero, sign and carry go to 0 next edge. clear in SETTLE is ignored.
- load and clear together in IDLE: load is accepted and clear is also applied. Flags go to 0 at that edge, then update normally at the end of SETTLE.
- Reset asserted at any time, including mid-SETTLE:
  - state goes to IDLE and the counter to 0;
  - busy, flags_valid, zero, sign, carry and overrun go to 0;
  - any in-flight capture is discarded.

## Timing
- Reset values: all outputs 0. The zero flag resets to 0, not 1: "no result evaluated".
- Load accepted at edge T:
  - busy is high in cycles T+1 through T+SETTLE;
  - flags update at edge T+SETTLE;
  - flags_valid is high in cycle T+SETTLE only.
- Latency from load to flags is SETTLE cycles.
- With SETTLE=1: busy high for one cycle, flags update the edge after acceptance.
- Back-to-back operation: load may be asserted in the flags_valid cycle and is accepted, since the state is IDLE. Maximum throughput is one evaluation per SETTLE+1 cycles.
- Flags hold their values indefinitely between updates.
- The counter width is enough to hold SETTLE-1; it never wraps.

## Structure
- Shared ALU package holds:
  - a state enum (IDLE, SETTLE);
  - a packed flag struct {zero, sign, carry} used by this block and the sequencer.
- One sub-module, `zero_chain`: combinational, parameterised by WIDTH. It ANDs the inverted bits in ripple order, bit 0 first, mirroring the relay chain, and outputs all-zero.
- Counter, FSM and flag registers live in the top block.

## Test plan
- Reset then idle, WIDTH=8, SETTLE=8:
  - all outputs 0;
  - load result=8'h00, carry_in=0 → busy for 8 cycles, then zero=1, sign=0, carry=0 with one flags_valid pulse.
- Load 8'h80 with carry_in=1 → after 8 cycles zero=0, sign=1, carry=1. Changing `result` mid-SETTLE has no effect on the flags.
- Load while busy, at cycle 3 of SETTLE → ignored and overrun=1. The original evaluation completes on schedule, and overrun stays set after later loads.
- Two cases in one scenario:
  - clear in IDLE after zero=1 → zero=0 next edge;
  - clear together with load of 8'h00 → flags 0 immediately, then zero=1 after SETTLE.
- Reset mid-SETTLE, cycle 4 → all outputs 0 and state IDLE. A following load of 8'h01 completes normally with zero=0.
- WIDTH=16, SETTLE=1:
  - load 16'h0000 → zero=1 one edge after acceptance;
  - load 16'h0100 in the flags_valid cycle is accepted → zero=0 at the next update.
